// File: rtl/fast_pkg.sv
// Shared definitions for the FAST corner pipeline: coordinate width,
// the corner FIFO entry layout and the drop-counter width.
package fast_pkg;

   localparam int COORD_WIDTH    = 10;
   localparam int DROP_CNT_WIDTH = 16;

   typedef struct packed {
      logic                   last;
      logic [COORD_WIDTH-1:0] y;
      logic [COORD_WIDTH-1:0] x;
   } corner_entry_t;

endpackage

// File: rtl/corner_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an extra pointer bit for
// full/empty and an exported occupancy level.
module corner_sync_fifo #(
   parameter int WIDTH = 21,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      level    = wr_ptr - rd_ptr;
      full     = (level == (AW+1)'(DEPTH));
      rd_valid = (wr_ptr != rd_ptr);
      do_push  = push && !full;
      do_pop   = pop && rd_valid;
      // Head is forced to zero while empty so the stream reads back clean.
      rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/corner_stream_packer.sv
// Packs the sparse corner strobe into a valid/ready stream with one
// end-of-frame marker per frame. Define CORNER_ROI_EN to drop border corners.
module corner_stream_packer #(
   parameter int COORD_WIDTH = 10,
   parameter int FIFO_DEPTH  = 64,
   parameter int MAX_CORNERS = 500,
   parameter int COL_NUM     = 640,
   parameter int ROW_NUM     = 480,
   parameter int ROI_BORDER  = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               ce,
   input  logic                               iscorner,
   input  logic [COORD_WIDTH-1:0]             x_coord,
   input  logic [COORD_WIDTH-1:0]             y_coord,
   input  logic                               frame_done,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [COORD_WIDTH-1:0]             out_x,
   output logic [COORD_WIDTH-1:0]             out_y,
   output logic                               out_last,
   output logic [COORD_WIDTH-1:0]             frame_corner_cnt,
   output logic                               overflow,
   output logic [fast_pkg::DROP_CNT_WIDTH-1:0] dropped_cnt
);

   import fast_pkg::*;

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = 2*COORD_WIDTH + 1;

   localparam logic [LW-1:0]          RESERVE_LVL = LW'(FIFO_DEPTH - 2);
   localparam logic [LW-1:0]          FULL_LVL    = LW'(FIFO_DEPTH);
   localparam logic [COORD_WIDTH-1:0] CAP         = COORD_WIDTH'(MAX_CORNERS);
   localparam logic [COORD_WIDTH-1:0] X_LO        = COORD_WIDTH'(ROI_BORDER);
   localparam logic [COORD_WIDTH-1:0] X_HI        = COORD_WIDTH'(COL_NUM - ROI_BORDER);
   localparam logic [COORD_WIDTH-1:0] Y_LO        = COORD_WIDTH'(ROI_BORDER);
   localparam logic [COORD_WIDTH-1:0] Y_HI        = COORD_WIDTH'(ROW_NUM - ROI_BORDER);

`ifdef CORNER_ROI_EN
   localparam logic ROI_EN = 1'b1;
`else
   localparam logic ROI_EN = 1'b0;
`endif

   logic                   in_roi;
   logic                   corner_ev;
   logic                   room;
   logic                   under_cap;
   logic                   accept;
   logic                   reject;
   logic                   marker_push;
   logic                   fifo_push;
   logic [EW-1:0]          wr_data;
   logic [EW-1:0]          rd_data;
   logic                   rd_valid;
   logic [LW-1:0]          level;
   logic [COORD_WIDTH-1:0] cur_cnt;
   logic                   marker_pending;

   always_comb begin
      in_roi      = (x_coord >= X_LO) && (x_coord < X_HI) &&
                    (y_coord >= Y_LO) && (y_coord < Y_HI);
      corner_ev   = ce && iscorner && (!ROI_EN || in_roi);
      // One slot stays free so the marker can always follow the last corner.
      room        = (level <= RESERVE_LVL);
      under_cap   = (cur_cnt < CAP);
      marker_push = marker_pending && (level != FULL_LVL);
      accept      = corner_ev && room && under_cap && !marker_pending;
      reject      = corner_ev && !accept;
      fifo_push   = marker_push || accept;
      wr_data     = marker_push ? {1'b1, {COORD_WIDTH{1'b0}}, frame_corner_cnt}
                                : {1'b0, y_coord, x_coord};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cur_cnt          <= '0;
         marker_pending   <= 1'b0;
         frame_corner_cnt <= '0;
         overflow         <= 1'b0;
         dropped_cnt      <= '0;
      end else begin
         if (reject && (dropped_cnt != {DROP_CNT_WIDTH{1'b1}}))
            dropped_cnt <= dropped_cnt + 1'b1;
         if (reject && !room)
            overflow <= 1'b1;
         // A frame_done seen while the previous marker is still queued is ignored.
         if (frame_done && !marker_pending) begin
            frame_corner_cnt <= cur_cnt + COORD_WIDTH'(accept);
            cur_cnt          <= '0;
            marker_pending   <= 1'b1;
         end else begin
            if (accept)      cur_cnt        <= cur_cnt + 1'b1;
            if (marker_push) marker_pending <= 1'b0;
         end
      end
   end

   corner_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .wr_data  (wr_data),
      .pop      (out_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .level    (level)
   );

   always_comb begin
      out_valid = rd_valid;
      out_last  = rd_data[EW-1];
      out_y     = rd_data[2*COORD_WIDTH-1:COORD_WIDTH];
      out_x     = rd_data[COORD_WIDTH-1:0];
   end

endmodule
